// File: rtl/mux_gate_alu_pkg.sv
// mux_gate_alu_pkg: shared opcode encoding and the per-op mux data-input
// selection used by every bit slice of mux_gate_alu.
//   OP_W        opcode width
//   op_e        opcode enum (AND..BUF)
//   mux_inputs  returns {i1, i0} for one bit, given the opcode and that B bit
package mux_gate_alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_XOR  = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    // y = a ? i1 : i0, so each function reduces to picking i0/i1 from
    // {0, 1, b, ~b}.
    function automatic logic [1:0] mux_inputs(input op_e op, input logic b);
        logic [1:0] sel;
        sel = 2'b00;
        case (op)
            OP_AND:  sel = {b,    1'b0};
            OP_OR:   sel = {1'b1, b   };
            OP_NOT:  sel = {1'b0, 1'b1};
            OP_NAND: sel = {~b,   1'b1};
            OP_NOR:  sel = {1'b0, ~b  };
            OP_XNOR: sel = {b,    ~b  };
            OP_XOR:  sel = {~b,   b   };
            OP_BUF:  sel = {1'b1, 1'b0};
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_gate_alu_if.sv
// mux_gate_alu_if: valid/ready operand stream in, valid/ready result stream
// out. The flag signals exist only when MUX_GATE_ALU_FLAGS_EN is defined.
//   master  drives operands and out_ready (the producer/consumer side)
//   slave   the ALU side
interface mux_gate_alu_if #(
    parameter int WIDTH = 8
);
    import mux_gate_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic             in_acc;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [OP_W-1:0]  out_op;
`ifdef MUX_GATE_ALU_FLAGS_EN
    logic             out_zero;
    logic             out_parity;
`endif

    modport master (
        output in_valid, in_op, in_acc, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_op
`ifdef MUX_GATE_ALU_FLAGS_EN
        , input out_zero, out_parity
`endif
    );

    modport slave (
        input  in_valid, in_op, in_acc, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_op
`ifdef MUX_GATE_ALU_FLAGS_EN
        , output out_zero, out_parity
`endif
    );

endinterface

// File: rtl/mux_gate_slice.sv
// mux_gate_slice: one result bit, a gate-level 2:1 mux (y = a ? i1 : i0).
//   a   select (operand A bit)
//   i0  data when a = 0
//   i1  data when a = 1
//   y   result bit
module mux_gate_slice (
    input  wire a,
    input  wire i0,
    input  wire i1,
    output wire y
);

    wire a_n;
    wire t0;
    wire t1;

    not u_inv (a_n, a);
    and u_and0 (t0, a_n, i0);
    and u_and1 (t1, a, i1);
    or  u_or (y, t0, t1);

endmodule

// File: rtl/mux_gate_alu.sv
// mux_gate_alu: two-stage pipelined bitwise logic unit with valid/ready
// backpressure and an accumulate mode (operand A taken from the previous
// result). Optional flags (out_zero, out_parity) under MUX_GATE_ALU_FLAGS_EN.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_gate_alu_if slave: in_* operand stream, out_* result stream
module mux_gate_alu
    import mux_gate_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_gate_alu_if.slave        bus
);

    logic             s1_valid;
    op_e              s1_op;
    logic             s1_acc;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             out_valid;
    logic [WIDTH-1:0] out_y;
    logic [OP_W-1:0]  out_op;
    logic [WIDTH-1:0] acc;

    logic             s1_load;
    logic             s2_load;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] y_next;

    assign s2_load  = s1_valid && (!out_valid || bus.out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = bus.in_valid && in_ready;

    // Accumulator is read when the beat is computed, not when accepted, so
    // back-to-back accumulate beats see the result just produced.
    assign op_a = s1_acc ? acc : s1_a;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic [1:0] sel;
        assign sel = mux_inputs(s1_op, s1_b[i]);
        mux_gate_slice u_slice (
            .a  (op_a[i]),
            .i0 (sel[0]),
            .i1 (sel[1]),
            .y  (y_next[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_AND;
            s1_acc    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_op    <= '0;
            acc       <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_op    <= op_e'(bus.in_op);
                s1_acc   <= bus.in_acc;
                s1_a     <= bus.in_a;
                s1_b     <= bus.in_b;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                out_y     <= y_next;
                out_op    <= s1_op;
                acc       <= y_next;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_GATE_ALU_FLAGS_EN
    logic out_zero;
    logic out_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
        end else if (s2_load) begin
            out_zero   <= (y_next == '0);
            out_parity <= ^y_next;
        end
    end

    assign bus.out_zero   = out_zero;
    assign bus.out_parity = out_parity;
`else
    // Flag registers and ports are not built.
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_y     = out_y;
    assign bus.out_op    = out_op;

endmodule
